// File: rtl/jump_input_conditioner.sv
// Jump push-button conditioner: synchroniser, four-state debouncer and a sticky
// jump request that the processor clears with jump_ack.
module jump_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        up_button,
  input  logic        jump_ack,
  output logic        io_jump,
  output logic        btn_level,
  output logic [15:0] press_count
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   press_event;

  assign sync = sync_chain[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous button input
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], up_button};
    end
  end

  // A press is accepted only on the final stable cycle of PRESS_CHK
  always_comb begin
    press_event = 1'b0;
    if ((state == PRESS_CHK) && sync && (cnt == LAST)) begin
      press_event = 1'b1;
    end else begin
      press_event = 1'b0;
    end
  end

  // Debounce FSM with registered level, sticky request and press counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RELEASED;
      cnt         <= '0;
      btn_level   <= 1'b0;
      io_jump     <= 1'b0;
      press_count <= 16'd0;
    end else begin
      case (state)
        RELEASED: begin
          if (sync) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!sync) begin
            state <= RELEASED;
          end else if (cnt == LAST) begin
            state     <= PRESSED;
            btn_level <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!sync) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end
        end
        RELEASE_CHK: begin
          if (sync) begin
            state <= PRESSED;
          end else if (cnt == LAST) begin
            state     <= RELEASED;
            btn_level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= RELEASED;
          cnt       <= '0;
          btn_level <= 1'b0;
        end
      endcase

      // Set beats clear so a press arriving with an ack is never lost
      if (press_event) begin
        io_jump <= 1'b1;
      end else if (jump_ack) begin
        io_jump <= 1'b0;
      end

      if (press_event && (press_count != 16'hFFFF)) begin
        press_count <= press_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/jump_input_conditioner.md
Name: jump_input_conditioner

Overview:
- Conditions the raw jump push-button before it reaches the processor's `io_jump` input.
- Synchronises the asynchronous button and debounces it with a four-state FSM.
- Converts each clean press into a sticky jump request that the processor clears with an acknowledge.
- Instantiated in the top-level wrapper between the board button pin and the CPU; also exports the debounced level and a press counter for debug.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `up_button` (legal ≥2).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (5 ms at 100 MHz; legal ≥1).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; all state is rising-edge.
- reset  in  1  asynchronous, active-low reset: 0 resets, 1 runs.
- up_button  in  1  raw, asynchronous, bouncing button level; 1 = pressed.
- jump_ack  in  1  processor has consumed the pending jump; sampled on the rising edge.
- io_jump  out  1  registered sticky jump request to the processor.
- btn_level  out  1  registered debounced button level.
- press_count  out  16  accepted presses since reset; saturating.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - all synchroniser flops = 0, FSM = RELEASED, debounce counter = 0;
  - io_jump = 0, btn_level = 0, press_count = 0.
- Reset mid-debounce or mid-request discards all state; no pending jump survives.
- After reset deasserts, operation resumes on the next rising edge.
- Synchroniser: a chain of SYNC_STAGES flops; `sync` is the last flop. The FSM reads only `sync`, never `up_button`.
- FSM states and transitions, evaluated each rising edge:
  - RELEASED: if sync=1, go to PRESS_CHK and set counter to 0; otherwise stay.
  - PRESS_CHK:
    - sync=0: back to RELEASED (bounce rejected, no event).
    - sync=1 and counter = DEBOUNCE_CYCLES-1: go to PRESSED and raise the press event.
    - otherwise: counter increments.
  - PRESSED: if sync=0, go to RELEASE_CHK and set counter to 0; otherwise stay.
  - RELEASE_CHK:
    - sync=1: back to PRESSED (no new event).
    - sync=0 and counter = DEBOUNCE_CYCLES-1: go to RELEASED.
    - otherwise: counter increments.
- btn_level is 1 exactly when the FSM is in PRESSED or RELEASE_CHK (registered, same edge as the state change).
- Latency: with up_button held high from before edge 0, io_jump rises on edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - SYNC_STAGES edges of synchroniser propagation, then DEBOUNCE_CYCLES edges in PRESS_CHK.
  - The transition into PRESS_CHK shares an edge with the first count.
  - Example: SYNC_STAGES=2, DEBOUNCE_CYCLES=4 gives edge 6.
  - Release takes the same number of edges to return btn_level to 0.
- A press event fires only on the PRESS_CHK→PRESSED transition. Holding the button generates no repeat.
- io_jump priority rules, per edge:
  - Press event: io_jump set to 1, whether or not jump_ack is asserted on the same edge (set beats clear, so a press is never lost).
  - jump_ack=1 with no press event: io_jump cleared to 0.
  - jump_ack while io_jump=0: no effect.
  - Press event while io_jump=1: io_jump stays 1; presses coalesce and are not queued.
- press_count increments by 1 on every press event, including coalesced ones. It saturates at 0xFFFF and never wraps.
- DEBOUNCE_CYCLES=1: a level is accepted after one stable cycle in a CHK state.
- Counter width: the counter never exceeds DEBOUNCE_CYCLES-1.
- All outputs are driven directly from flops; there is no combinational path from any input to any output.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Clean press: reset low for 3 cycles, then up_button=1 held →
  - io_jump=1 and btn_level=1 at edge 6;
  - press_count=1;
  - io_jump stays 1 indefinitely with jump_ack=0.
- Bounce rejection: up_button pulses 1,0,1,0,1 one cycle each, then 0 →
  - io_jump, btn_level and press_count all remain 0.
- Ack handshake: after a clean press, jump_ack=1 for one cycle → io_jump=0 on the next edge.
  - Hold the button 20 cycles, release, press again → io_jump=1 again; press_count=2.
- Simultaneous set/clear: drive jump_ack=1 on exactly the edge of a second press event while io_jump=1 →
  - io_jump remains 1; press_count increments.
  - A further 1-cycle jump_ack clears io_jump.
- Reset mid-operation: assert reset during PRESS_CHK and again while io_jump=1 →
  - all outputs go to 0 immediately without a clock edge.
  - After reset deasserts with the button held high, io_jump rises 6 edges later.
- Saturation: force 65537 clean press/release cycles (or preload via a bench-only DEBOUNCE_CYCLES=1 build) →
  - press_count reads 0xFFFF and never wraps to 0.
